// File: rtl/filters_mc_ram.sv
// Multi-channel simple-dual-port RAM with a post-reset clear sweep, read-valid handshake and optional output register.
// Define FILTERS_MC_RAM_RDW_BYPASS_EN to return new write data on a same-cycle read/write to the same word.
module filters_mc_ram #(
  parameter int    DWIDTH   = 16,
  parameter int    AWIDTH   = 8,
  parameter int    NCH      = 4,
  parameter int    OUT_REG  = 0,
  parameter string RAMSTYLE = "M9K",
  parameter int    CHW      = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int    DEPTH    = NCH * (2 ** AWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHW-1:0]    wrch,
  input  logic [AWIDTH-1:0] wraddr,
  input  logic              wren,
  input  logic [DWIDTH-1:0] d,
  input  logic [CHW-1:0]    rdch,
  input  logic [AWIDTH-1:0] rdaddr,
  input  logic              rden,
  output logic [DWIDTH-1:0] q,
  output logic              qvalid,
  output logic              init_busy
);
  localparam int IW = CHW + AWIDTH;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  if (RAMSTYLE != "M9K" && RAMSTYLE != "logic" && RAMSTYLE != "default") begin : g_bad_style
    $fatal(1, "filters_mc_ram: unsupported RAMSTYLE");
  end

  typedef enum logic {S_INIT, S_READY} state_t;
  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state == S_INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == LAST) begin
        r_state <= S_READY;
        r_busy  <= 1'b0;
      end
    end
  end

  logic              w_wr_inrng, w_rd_inrng, w_wr_ok, w_rd_ok;
  logic              w_mwe, w_mre;
  logic [IW-1:0]     w_widx, w_ridx, w_mwidx;
  logic [DWIDTH-1:0] w_mwd, w_mem_q, w_q1;

  assign w_widx     = {wrch, wraddr};
  assign w_ridx     = {rdch, rdaddr};
  assign w_wr_inrng = 32'(wrch) < NCH;
  assign w_rd_inrng = 32'(rdch) < NCH;
  assign w_wr_ok    = !rst && !r_busy && wren && w_wr_inrng;
  assign w_rd_ok    = !rst && !r_busy && rden;

  // The sweep owns the write port while busy; user writes take it afterwards.
  assign w_mwe   = !rst && (r_busy || w_wr_ok);
  assign w_mwidx = r_busy ? r_ptr : w_widx;
  assign w_mwd   = r_busy ? '0 : d;
  assign w_mre   = w_rd_ok && w_rd_inrng;

  if (RAMSTYLE == "logic") begin : g_mem_logic
    (* ramstyle = "logic" *) logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_mwe) r_mem[w_mwidx] <= w_mwd;
      if (w_mre) r_rd <= r_mem[w_ridx];
    end
    assign w_mem_q = r_rd;
  end else if (RAMSTYLE == "M9K") begin : g_mem_m9k
    (* ramstyle = "M9K" *) logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_mwe) r_mem[w_mwidx] <= w_mwd;
      if (w_mre) r_rd <= r_mem[w_ridx];
    end
    assign w_mem_q = r_rd;
  end else begin : g_mem_dflt
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_mwe) r_mem[w_mwidx] <= w_mwd;
      if (w_mre) r_rd <= r_mem[w_ridx];
    end
    assign w_mem_q = r_rd;
  end

  // r_zero masks the uninitialised RAM output after reset and forces 0 for out-of-range reads.
  logic r_vld1, r_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld1 <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_vld1 <= w_rd_ok;
      if (w_rd_ok) r_zero <= !w_rd_inrng;
    end
  end

`ifdef FILTERS_MC_RAM_RDW_BYPASS_EN
  // Addresses are captured with each read and compared after the edge, off the input path.
  logic              r_byp_en;
  logic [IW-1:0]     r_byp_widx, r_byp_ridx;
  logic [DWIDTH-1:0] r_byp_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_en <= 1'b0;
    end else if (w_rd_ok) begin
      r_byp_en   <= w_wr_ok;
      r_byp_widx <= w_widx;
      r_byp_ridx <= w_ridx;
      r_byp_d    <= d;
    end
  end
  assign w_q1 = r_zero ? '0 :
                (r_byp_en && r_byp_widx == r_byp_ridx) ? r_byp_d : w_mem_q;
`else
  assign w_q1 = r_zero ? '0 : w_mem_q;
`endif

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] r_q2;
    logic              r_vld2;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q2   <= '0;
        r_vld2 <= 1'b0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_q2 <= w_q1;
      end
    end
    assign q      = r_q2;
    assign qvalid = r_vld2;
  end else begin : g_noreg
    assign q      = w_q1;
    assign qvalid = r_vld1;
  end

  assign init_busy = r_busy;
endmodule

// File: doc/filters_mc_ram.md
Name: filters_mc_ram

Overview:
Multi-channel simple-dual-port RAM for the filter datapaths, such as time-multiplexed FIR/IIR delay lines with one memory shared by NCH channels.
- Each channel owns an independent 2**AWIDTH-word region, addressed by channel index plus word address.
- After every reset, a built-in sweep FSM clears the whole array to zero, so hardware and simulation both start from a known state.
- Provides a read-valid handshake, an optional output pipeline register and selectable read-during-write semantics.

Parameters:
DWIDTH, 16, data word width
AWIDTH, 8, per-channel address width; per-channel depth = 2**AWIDTH
NCH, 4, number of channels, >=1; need not be a power of two
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
RAMSTYLE, "M9K", synthesis memory style: "M9K", "logic" or "default"; any other value is $fatal in simulation
CHW, (NCH>1 ? $clog2(NCH) : 1), derived channel-index width; not to be overridden
DEPTH, NCH*2**AWIDTH, derived total words; not to be overridden

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wrch  in  CHW  write channel index
wraddr  in  AWIDTH  write word address within the channel
wren  in  1  write enable
d  in  DWIDTH  write data
rdch  in  CHW  read channel index
rdaddr  in  AWIDTH  read word address within the channel
rden  in  1  read request
q  out  DWIDTH  read data
qvalid  out  1  one-cycle pulse marking q valid for one rden
init_busy  out  1  clear sweep in progress; user access ignored while high

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes happen on posedge clk.
- Physical word index = wrch*2**AWIDTH + wraddr; reads use the same mapping with rdch/rdaddr.
- Reset values: q=0, qvalid=0, init_busy=1, FSM=INIT, sweep pointer=0, output pipeline flushed.
- FSM states:
  - INIT: writes 0 to word[pointer] every cycle and increments pointer. When the word at DEPTH-1 is written, moves to READY.
  - READY: normal operation; stays here until rst.
- Sweep timing: init_busy stays 1 for exactly DEPTH clock edges after the first edge with rst low, then reads 0.
- During INIT and during rst:
  - wren and rden are ignored.
  - qvalid stays 0 and q stays 0.
- Write: in READY with wren=1, word <= d at the edge.
- Read latency:
  - OUT_REG=0: rden=1 at edge t gives q and qvalid=1 after edge t (visible in cycle t+1).
  - OUT_REG=1: the result appears one edge later.
- Reads issued on consecutive cycles produce qvalid pulses on consecutive cycles (full throughput).
- q holds its last value when qvalid=0.
- Channel out of range (ch >= NCH, only possible when NCH is not a power of two):
  - Write is dropped.
  - Read returns q=0 with qvalid=1, so the handshake is preserved.
- Read-during-write to the same physical word in the same cycle: see Optional Feature. Writes and reads to different words never interact.
- rst asserted mid-operation:
  - In-flight reads are discarded (no qvalid).
  - Sweep restarts from pointer 0, even if a previous sweep was unfinished.
- Same-word reads issued in the cycle after a write return the new data in both configurations.

Optional Feature:
Macro FILTERS_MC_RAM_RDW_BYPASS_EN.
- Defined: a same-cycle read and write to the same physical word returns the new data d. Implemented by comparing addresses and muxing d into the read register; the comparison uses the registered address so timing stays clean.
- Undefined: the same collision returns the old stored word (plain memory behaviour); no bypass logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Init sweep: DEPTH=1024 (NCH=4, AWIDTH=8); release rst → init_busy falls after exactly 1024 edges; reading all 1024 words gives q=0 with a qvalid pulse for every read.
- Basic latency: write ch2/addr5=0x1234, then rden ch2/addr5 at edge t → q=0x1234, qvalid=1 in cycle t+1 (OUT_REG=0) or t+2 (OUT_REG=1).
- Channel isolation: write ch0/addr5=0xAAAA and ch3/addr5=0x5555; read both → 0xAAAA and 0x5555; ch1/addr5 reads 0.
- Collision: word holds 0x0001; write 0xBEEF and read the same word in the same cycle → q=0xBEEF with the macro defined, 0x0001 without; a read on the next cycle → 0xBEEF in both builds.
- Out-of-range channel with NCH=3: write ch3=0x7777, then read ch3 → q=0, qvalid=1; every valid channel is unchanged.
- Reset mid-operation: with rden held high, assert rst during a write burst → qvalid=0 and init_busy=1 on the following edge; after a full re-sweep every word reads 0.
